// File: rtl/fetch_ctrl_pkg.sv
// Shared types and default sizing for the fetch controller and its return stack.
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam int unsigned DEF_PC_W     = 9;
  localparam int unsigned DEF_RS_DEPTH = 4;
  localparam int unsigned DEF_CNT_W    = 16;

endpackage

// File: rtl/fetch_ctrl_ret_stack.sv
// Return-address stack; reset and clear touch only the pointer, entries are plain storage.
module ret_stack #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 9
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [Width-1:0] i_data,
  output logic [Width-1:0] o_top,
  output logic             o_empty,
  output logic             o_full
);

  // One extra pointer bit keeps full (ptr == Depth) distinct from empty (ptr == 0).
  localparam int unsigned PtrW = $clog2(Depth) + 1;
  localparam int unsigned IdxW = $clog2(Depth);

  logic [PtrW-1:0]  r_ptr;
  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  w_top_ptr;

  assign o_empty   = (r_ptr == '0);
  assign o_full    = (r_ptr == PtrW'(Depth));
  assign w_top_ptr = r_ptr - PtrW'(1);
  assign o_top     = r_mem[w_top_ptr[IdxW-1:0]];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ptr <= '0;
    end else if (i_clear) begin
      r_ptr <= '0;
    end else if (i_push && !o_full) begin
      r_ptr <= r_ptr + PtrW'(1);
    end else if (i_pop && !o_empty) begin
      r_ptr <= r_ptr - PtrW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !o_full && !i_clear) begin
      r_mem[r_ptr[IdxW-1:0]] <= i_data;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: pc update, call/return stack, retire counter and halt handling.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned PC_W     = DEF_PC_W,
  parameter int unsigned RS_DEPTH = DEF_RS_DEPTH,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [PC_W-1:0]  i_start_addr,
  input  logic             i_stall,
  input  logic             i_halt,
  input  logic             i_branch,
  input  logic [PC_W-1:0]  i_address,
  input  logic             i_call,
  input  logic             i_ret,
  output logic [PC_W-1:0]  o_pc,
  output logic             o_running,
  output logic             o_done,
  output logic [CNT_W-1:0] o_instr_count,
  output logic             o_stack_err
);

  state_e           r_state, w_state_d;
  logic [PC_W-1:0]  r_pc, w_pc_d, w_pc_inc;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic             r_err, w_err_d;
  logic             w_retire, w_push, w_pop, w_clear;
  logic [PC_W-1:0]  w_top;
  logic             w_empty, w_full;

  assign w_pc_inc = r_pc + PC_W'(1);

  ret_stack #(
    .Depth (RS_DEPTH),
    .Width (PC_W)
  ) u_ret_stack (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (w_clear),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_pc_inc),
    .o_top   (w_top),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  always_comb begin
    w_state_d = r_state;
    w_pc_d    = r_pc;
    w_cnt_d   = r_cnt;
    w_err_d   = r_err;
    w_retire  = 1'b0;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_clear   = 1'b0;
    unique case (r_state)
      StIdle, StDone: begin
        if (i_start) begin
          w_state_d = StRun;
          w_pc_d    = i_start_addr;
          w_cnt_d   = '0;
          w_err_d   = 1'b0;
          w_clear   = 1'b1;
        end
      end
      StRun: begin
        if (!i_stall) begin
          w_retire = 1'b1;
          if (i_halt) begin
            w_state_d = StDone;
          end else if (i_ret) begin
            if (w_empty) begin
              w_err_d = 1'b1;
              w_pc_d  = w_pc_inc;
            end else begin
              w_pop  = 1'b1;
              w_pc_d = w_top;
            end
          end else if (i_call || i_branch) begin
            if (i_call) begin
              if (w_full) w_err_d = 1'b1;
              else        w_push  = 1'b1;
            end
            w_pc_d = i_address;
          end else if (r_pc == {PC_W{1'b1}}) begin
            // Running off the top of the address space ends the program.
            w_state_d = StDone;
          end else begin
            w_pc_d = w_pc_inc;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
    if (w_retire && (r_cnt != {CNT_W{1'b1}})) begin
      w_cnt_d = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_pc    <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_pc    <= w_pc_d;
      r_cnt   <= w_cnt_d;
      r_err   <= w_err_d;
    end
  end

  assign o_pc          = r_pc;
  assign o_running     = (r_state == StRun);
  assign o_done        = (r_state == StDone);
  assign o_instr_count = r_cnt;
  assign o_stack_err   = r_err;

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter PC_W, default 9, program-counter width; matches the 9-bit branch address.
REQ-002 Parameter RS_DEPTH, default 4, return-stack entries.
REQ-003 Parameter CNT_W, default 16, retired-instruction counter width.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  begin execution at start_addr; honoured only in IDLE or DONE.
REQ-007 start_addr  input  PC_W  first instruction address.
REQ-008 stall  input  1  hold pc this cycle; no retirement.
REQ-009 halt  input  1  instruction at pc is a halt.
REQ-010 branch  input  1  branch taken, from the branch unit.
REQ-011 address  input  PC_W  branch/call target (immediate << 3, already formed).
REQ-012 call  input  1  taken branch that also pushes a return address.
REQ-013 ret  input  1  return; pop the return stack into pc.
REQ-014 pc  output  PC_W  current instruction address.
REQ-015 running  output  1  high in RUN.
REQ-016 done  output  1  high in DONE.
REQ-017 instr_count  output  CNT_W  instructions retired since the last start.
REQ-018 stack_err  output  1  sticky return-stack overflow/underflow.

Function
REQ-019 States are IDLE, RUN and DONE; control inputs other than start are ignored outside RUN.
REQ-020 IDLE/DONE + start: next cycle state=RUN, pc=start_addr, instr_count=0, stack empty, stack_err=0.
REQ-021 RUN priority, highest first: stall > halt > ret > (call|branch) > sequential.
REQ-022 stall: pc, stack, count and state all hold.
REQ-023 halt: state->DONE, pc holds, count+1.
REQ-024 ret with non-empty stack: pc=top entry, pop, count+1.
REQ-025 ret with empty stack: stack_err=1, pc=pc+1, count+1.
REQ-026 call: push pc+1, pc=address, count+1; when the stack is full, no push, stack_err=1, jump still taken.
REQ-027 branch without call: pc=address, count+1; the stack is untouched.
REQ-028 sequential: pc=pc+1, count+1.
REQ-029 Sequential advance from pc = 2^PC_W-1: no wrap; state->DONE, pc holds, count+1.
REQ-030 instr_count saturates at 2^CNT_W-1.
REQ-031 Every pc change is registered: one cycle from the input to the new pc; no combinational input-to-pc path.
REQ-032 Simultaneous call and ret: ret wins per REQ-021; call is ignored.
REQ-033 A start asserted while in RUN is ignored.

Reset
REQ-034 reset asserted at any time, including mid-RUN: state=IDLE, pc=0, instr_count=0, stack empty, stack_err=0, running=0, done=0, immediately and independent of clk.
REQ-035 The first start is accepted on the first posedge clk after reset deasserts.

Structure
REQ-036 A shared package holds the state enum (IDLE, RUN, DONE) and the default values for PC_W, RS_DEPTH and CNT_W.
REQ-037 The return stack is one sub-module, ret_stack: push, pop, top, empty, full, and an asynchronous reset that clears the pointer only.
REQ-038 The stack pointer width is $clog2(RS_DEPTH)+1 so that full and empty are distinguishable.

Verification
REQ-039 reset, start with start_addr=0x010, 5 idle cycles -> pc steps 0x010..0x015, instr_count=5, running=1.
REQ-040 RUN at pc=0x020, branch=1 with address=0x048 -> next pc=0x048; stall=1 in the same cycle -> pc holds 0x020, count unchanged.
REQ-041 call at 0x030 with address=0x100, then ret at 0x105 -> pc 0x100, then 0x031; stack_err=0.
REQ-042 Five nested calls with RS_DEPTH=4 -> stack_err=1 on the fifth call, jump still taken; four rets restore the correct addresses; a fifth ret -> pc+1, stack_err stays 1.
REQ-043 halt at 0x040 -> done=1, pc=0x040; a new start with start_addr=0x000 -> RUN, count=0; start_addr=0x1FF followed by a sequential advance -> DONE, pc=0x1FF.
REQ-044 reset pulse between clock edges mid-RUN with pc=0x0A3 -> pc=0 and state IDLE before the next edge.
